syrup_traffic_gen: RTL and testbench
====================================

SYRUP_TRAFFIC_GEN -- requirements
Module: syrup_traffic_gen

Interface
REQ-001 SHALL have parameter LED_WIDTH, default 8, width of LED output.
REQ-002 SHALL have parameter W_A, default 24, memory address width.
REQ-003 SHALL have parameter W_D, default 32, memory data width.
REQ-004 SHALL have parameter NUM_WORDS, default 256, accesses per phase (>=1).
REQ-005 SHALL have parameter STRIDE, default 4, address increment per access.
REQ-006 SHALL have parameter BASE_ADDR, default 0, first access address.
REQ-007 SHALL have parameter PATTERN_SEED, default 32'h0000_1000, write-data base value.
REQ-008 SHALL have parameter RD_LATENCY, default 1, cycles from MEM_RE to valid MEM_Q (>=1).
REQ-009 SHALL have a single clock and synchronous, active-high reset: CLK  in  1  clock, all logic on rising edge.
REQ-010 SHALL have RST  in  1  synchronous active-high reset.
REQ-011 SHALL have START  in  1  run request.
REQ-012 SHALL have BUSY  out  1  run in progress; DONE  out  1  one-cycle completion pulse.
REQ-013 SHALL have ERROR  out  1  sticky mismatch flag; ERR_COUNT  out  16  mismatch count.
REQ-014 SHALL have LED  out  LED_WIDTH  low bits of last captured read data.
REQ-015 SHALL have MEM_ADDR  out  W_A; MEM_D  out  W_D; MEM_WE  out  1; MEM_RE  out  1; MEM_BE  out  W_D/8, all ones during writes, else 0.
REQ-016 SHALL have MEM_Q  in  W_D  read data from a SyrupMemory1P-style single-port memory.

Function
REQ-017 FSM states SHALL be IDLE, WRITE, READ, DRAIN, FIN.
REQ-018 START SHALL be sampled only in IDLE; in other states it SHALL be ignored.
REQ-019 START in IDLE SHALL clear idx, ERROR, ERR_COUNT and move to WRITE next cycle.
REQ-020 WRITE SHALL issue NUM_WORDS consecutive cycles with MEM_WE=1, MEM_RE=0, then go to READ.
REQ-021 READ SHALL issue NUM_WORDS consecutive cycles with MEM_RE=1, MEM_WE=0, then go to DRAIN.
REQ-022 Access idx (0..NUM_WORDS-1) SHALL use MEM_ADDR = (BASE_ADDR + idx*STRIDE) mod 2^W_A, wrapping silently.
REQ-023 Write data for idx SHALL be (PATTERN_SEED + idx) mod 2^W_D; expected read data identical.
REQ-024 Expected data SHALL be delayed RD_LATENCY cycles alongside a valid bit, and compared with MEM_Q when valid.
REQ-025 DRAIN SHALL last exactly RD_LATENCY cycles so the final read is compared, then go to FIN.
REQ-026 FIN SHALL assert DONE for exactly one cycle then return to IDLE.
REQ-027 BUSY SHALL be 1 in WRITE, READ, DRAIN, FIN; 0 in IDLE.
REQ-028 MEM_WE, MEM_RE SHALL be 0 outside WRITE/READ; MEM_ADDR, MEM_D SHALL be registered outputs.
REQ-029 ERR_COUNT SHALL saturate at 16'hFFFF; ERROR SHALL set on first mismatch and hold until next START.
REQ-030 LED SHALL update with MEM_Q[LED_WIDTH-1:0] on each valid compare cycle.
REQ-031 DONE SHALL assert exactly 2*NUM_WORDS+RD_LATENCY+1 cycles after the START-sampling edge.

Reset
REQ-032 RST SHALL force IDLE; BUSY, DONE, ERROR, ERR_COUNT, LED, MEM_* all 0; delay-line valid bits cleared.
REQ-033 RST mid-run SHALL abort immediately; in-flight reads SHALL be discarded, no DONE.

Configuration
REQ-034 With SYRUP_TRAFFIC_CHECK_EN defined, compare logic, ERROR, ERR_COUNT SHALL be implemented per REQ-024/029.
REQ-035 Without SYRUP_TRAFFIC_CHECK_EN, no compare logic SHALL exist; ERROR and ERR_COUNT SHALL be constant 0; timing and LED unchanged.

Structure
REQ-036 Package syrup_traffic_pkg SHALL hold FSM state encoding and ERR_COUNT width constant (16).
REQ-037 Sub-module syrup_delay_line (parametrised width, depth RD_LATENCY, with valid) SHALL carry expected data.

Verification
REQ-038 NUM_WORDS=4, STRIDE=4, BASE_ADDR=0x100, ideal memory latency 1: writes 0x100..0x10C data 0x1000..0x1003, reads same, DONE 10 cycles after START, ERR_COUNT=0.
REQ-039 Memory model corrupts read at 0x108: ERROR=1, ERR_COUNT=1 at DONE; next START clears both.
REQ-040 BASE_ADDR=0xFFFFF8, W_A=24, STRIDE=4, NUM_WORDS=4: addresses 0xFFFFF8, 0xFFFFFC, 0x000000, 0x000004.
REQ-041 RD_LATENCY=3, NUM_WORDS=2: DRAIN 3 cycles, DONE 8 cycles after START, all compares pass.
REQ-042 RST asserted during READ: next cycle BUSY=0, MEM_RE=0, no DONE; subsequent START runs cleanly.
REQ-043 START held high throughout run: ignored while BUSY; new run begins only after return to IDLE.

Source files
------------

// File: rtl/syrup_traffic_pkg.sv
// Shared definitions for the syrup traffic generator.
//   state_t / ST_*  : FSM state encoding (legacy-compatible 3-bit constants)
//   ERR_CNT_W       : width of the saturating mismatch counter
package syrup_traffic_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WRITE = 3'd1;
  localparam state_t ST_READ  = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_FIN   = 3'd4;

  localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/syrup_traffic_gen_if.sv
// Single-port memory bus between the traffic generator (master) and a
// SyrupMemory1P-style memory (slave).
//   MEM_ADDR : access address
//   MEM_D    : write data
//   MEM_WE   : write enable
//   MEM_RE   : read enable
//   MEM_BE   : byte enables, all ones during writes
//   MEM_Q    : read data, valid a fixed latency after MEM_RE
interface syrup_traffic_gen_if #(
  parameter int W_A = 24,
  parameter int W_D = 32
);

  logic [W_A-1:0]   MEM_ADDR;
  logic [W_D-1:0]   MEM_D;
  logic             MEM_WE;
  logic             MEM_RE;
  logic [W_D/8-1:0] MEM_BE;
  logic [W_D-1:0]   MEM_Q;

  modport master (
    output MEM_ADDR, MEM_D, MEM_WE, MEM_RE, MEM_BE,
    input  MEM_Q
  );

  modport slave (
    input  MEM_ADDR, MEM_D, MEM_WE, MEM_RE, MEM_BE,
    output MEM_Q
  );

endinterface

// File: rtl/syrup_delay_line.sv
// Fixed-depth delay line with a valid bit travelling beside the data.
// Only the valid bits are reset; data registers simply follow.
//   clk_i, rst_i : clock, synchronous active-high reset
//   vld_i/data_i : input sample
//   vld_o/data_o : sample delayed by DEPTH cycles
module syrup_delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      for (int i = 1; i < DEPTH; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    data_q[0] <= data_i;
    for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign data_o = data_q[DEPTH-1];

endmodule

// File: rtl/syrup_traffic_gen.sv
// Memory traffic generator: on START it writes NUM_WORDS words of an
// incrementing pattern, reads them back, and (optionally) checks them.
// Optional feature macro: SYRUP_TRAFFIC_CHECK_EN enables read-data compare,
// ERROR and ERR_COUNT; without it both outputs are constant 0.
// Ports:
//   CLK, RST   : clock, synchronous active-high reset
//   START      : run request, sampled only while idle
//   BUSY, DONE : run in progress / one-cycle completion pulse
//   ERROR      : sticky mismatch flag, ERR_COUNT: saturating mismatch count
//   LED        : low bits of the last captured read data
//   mem        : memory bus master port
module syrup_traffic_gen
  import syrup_traffic_pkg::*;
#(
  parameter int             LED_WIDTH    = 8,
  parameter int             W_A          = 24,
  parameter int             W_D          = 32,
  parameter int             NUM_WORDS    = 256,
  parameter int             STRIDE       = 4,
  parameter logic [W_A-1:0] BASE_ADDR    = '0,
  parameter logic [31:0]    PATTERN_SEED = 32'h0000_1000,
  parameter int             RD_LATENCY   = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERROR,
  output logic [ERR_CNT_W-1:0] ERR_COUNT,
  output logic [LED_WIDTH-1:0] LED,
  syrup_traffic_gen_if.master  mem
);

  // One counter serves both the access index and the drain count.
  localparam int CNT_MAX = (NUM_WORDS > RD_LATENCY) ? NUM_WORDS : RD_LATENCY;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(RD_LATENCY - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [W_A-1:0]   addr_q, addr_d;
  logic [W_D-1:0]   wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             re_q, re_d;
  logic [LED_WIDTH-1:0] led_q;
  logic             start_clr;
  logic             cmp_vld;

  assign start_clr = (state_q == ST_IDLE) && START;

  // Registered outputs are computed for the access about to be presented,
  // so MEM_* line up with state_q/idx_q in the same cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_WRITE;
          idx_d   = '0;
          addr_d  = BASE_ADDR;
          wdata_d = W_D'(PATTERN_SEED);
          we_d    = 1'b1;
        end
      end
      ST_WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_READ;
          idx_d   = '0;
          addr_d  = BASE_ADDR;
          wdata_d = '0;
          re_d    = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          addr_d  = addr_q + W_A'(STRIDE);
          wdata_d = wdata_q + 1'b1;
          we_d    = 1'b1;
        end
      end
      ST_READ: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
          idx_d   = '0;
          addr_d  = '0;
        end else begin
          idx_d   = idx_q + 1'b1;
          addr_d  = addr_q + W_A'(STRIDE);
          re_d    = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (idx_q == LAST_DRAIN) state_d = ST_FIN;
        else                     idx_d   = idx_q + 1'b1;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
    end
  end

`ifdef SYRUP_TRAFFIC_CHECK_EN
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [W_D-1:0]       exp_in, exp_out;
  logic                 error_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Expected data equals the write pattern for the index being read.
  assign exp_in = W_D'(PATTERN_SEED) + W_D'(idx_q);

  syrup_delay_line #(
    .WIDTH (W_D),
    .DEPTH (RD_LATENCY)
  ) u_exp_dly (
    .clk_i  (CLK),
    .rst_i  (RST),
    .vld_i  (re_q),
    .data_i (exp_in),
    .vld_o  (cmp_vld),
    .data_o (exp_out)
  );

  // --- compare stage: MEM_Q against delayed expected data ---
  always_ff @(posedge CLK) begin
    if (RST || start_clr) begin
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else if (cmp_vld && (mem.MEM_Q != exp_out)) begin
      error_q   <= 1'b1;
      err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  assign ERROR     = error_q;
  assign ERR_COUNT = err_cnt_q;
`else
  // Without checking only the valid timing is needed, to drive LED capture.
  logic [RD_LATENCY-1:0] vld_sr_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_sr_q <= '0;
    end else begin
      vld_sr_q[0] <= re_q;
      for (int i = 1; i < RD_LATENCY; i++) vld_sr_q[i] <= vld_sr_q[i-1];
    end
  end

  assign cmp_vld   = vld_sr_q[RD_LATENCY-1];
  assign ERROR     = 1'b0;
  assign ERR_COUNT = '0;
`endif

  always_ff @(posedge CLK) begin
    if (RST)          led_q <= '0;
    else if (cmp_vld) led_q <= mem.MEM_Q[LED_WIDTH-1:0];
  end

  assign BUSY         = (state_q != ST_IDLE);
  assign DONE         = (state_q == ST_FIN);
  assign LED          = led_q;
  assign mem.MEM_ADDR = addr_q;
  assign mem.MEM_D    = wdata_q;
  assign mem.MEM_WE   = we_q;
  assign mem.MEM_RE   = re_q;
  assign mem.MEM_BE   = {(W_D/8){we_q}};

endmodule

// File: tb/tb_syrup_traffic_gen.sv
// Directed bench for syrup_traffic_gen: three instances cover the base
// address/latency-1 case, address wraparound, and read latency 3.
module tb_syrup_traffic_gen;

`ifdef SYRUP_TRAFFIC_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic CLK, RST;
  logic START0, START1, START2;
  logic BUSY0, DONE0, ERROR0; logic [15:0] ERRC0; logic [7:0] LED0;
  logic BUSY1, DONE1, ERROR1; logic [15:0] ERRC1; logic [7:0] LED1;
  logic BUSY2, DONE2, ERROR2; logic [15:0] ERRC2; logic [7:0] LED2;
  int n_cmp, n_bad;

  syrup_traffic_gen_if #(.W_A(24), .W_D(32)) if0 ();
  syrup_traffic_gen_if #(.W_A(24), .W_D(32)) if1 ();
  syrup_traffic_gen_if #(.W_A(24), .W_D(32)) if2 ();

  syrup_traffic_gen #(.NUM_WORDS(4), .STRIDE(4), .BASE_ADDR(24'h000100), .RD_LATENCY(1)) dut0 (
    .CLK(CLK), .RST(RST), .START(START0), .BUSY(BUSY0), .DONE(DONE0),
    .ERROR(ERROR0), .ERR_COUNT(ERRC0), .LED(LED0), .mem(if0));
  syrup_traffic_gen #(.NUM_WORDS(4), .STRIDE(4), .BASE_ADDR(24'hFFFFF8), .RD_LATENCY(1)) dut1 (
    .CLK(CLK), .RST(RST), .START(START1), .BUSY(BUSY1), .DONE(DONE1),
    .ERROR(ERROR1), .ERR_COUNT(ERRC1), .LED(LED1), .mem(if1));
  syrup_traffic_gen #(.NUM_WORDS(2), .STRIDE(4), .BASE_ADDR(24'h000000), .RD_LATENCY(3)) dut2 (
    .CLK(CLK), .RST(RST), .START(START2), .BUSY(BUSY2), .DONE(DONE2),
    .ERROR(ERROR2), .ERR_COUNT(ERRC2), .LED(LED2), .mem(if2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory models, word-indexed by address bits [9:2].
  logic [31:0] mem0 [256], mem1 [256], mem2 [256];
  logic [31:0] q0, q1, q2a, q2b, q2c;
  logic        corrupt_en0;
  logic [23:0] corrupt_addr0;

  always @(posedge CLK) begin
    if (if0.MEM_WE) mem0[if0.MEM_ADDR[9:2]] <= if0.MEM_D;
    if (if0.MEM_RE) q0 <= mem0[if0.MEM_ADDR[9:2]] ^
        ((corrupt_en0 && if0.MEM_ADDR == corrupt_addr0) ? 32'h0000_00FF : 32'h0);
    if (if1.MEM_WE) mem1[if1.MEM_ADDR[9:2]] <= if1.MEM_D;
    if (if1.MEM_RE) q1 <= mem1[if1.MEM_ADDR[9:2]];
    if (if2.MEM_WE) mem2[if2.MEM_ADDR[9:2]] <= if2.MEM_D;
    if (if2.MEM_RE) q2a <= mem2[if2.MEM_ADDR[9:2]];
    q2b <= q2a;
    q2c <= q2b;
  end

  assign if0.MEM_Q = q0;
  assign if1.MEM_Q = q1;
  assign if2.MEM_Q = q2c;

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++; if (BUSY0 !== 1'b0 || DONE0 !== 1'b0) begin n_bad++; $display("FAIL rst_busy_done: got %b%b want 00", BUSY0, DONE0); end
    n_cmp++; if (ERROR0 !== 1'b0 || ERRC0 !== 16'h0) begin n_bad++; $display("FAIL rst_err: got %b/%0h want 0/0", ERROR0, ERRC0); end
    n_cmp++; if (LED0 !== 8'h0) begin n_bad++; $display("FAIL rst_led: got %0h want 0", LED0); end
    n_cmp++; if ({if0.MEM_WE, if0.MEM_RE, if0.MEM_BE} !== 6'b0) begin n_bad++; $display("FAIL rst_mem_ctl: got %b want 0", {if0.MEM_WE, if0.MEM_RE, if0.MEM_BE}); end
    n_cmp++; if (if0.MEM_ADDR !== 24'h0 || if0.MEM_D !== 32'h0) begin n_bad++; $display("FAIL rst_mem_bus: got %0h/%0h want 0/0", if0.MEM_ADDR, if0.MEM_D); end
    n_cmp++; if (BUSY1 !== 1'b0 || BUSY2 !== 1'b0) begin n_bad++; $display("FAIL rst_busy12: got %b%b want 00", BUSY1, BUSY2); end
    RST = 1'b0;
    @(negedge CLK);
    n_cmp++; if (BUSY0 !== 1'b0 || if0.MEM_WE !== 1'b0) begin n_bad++; $display("FAIL rst_idle_after: got %b%b want 00", BUSY0, if0.MEM_WE); end
  endtask

  task automatic test_basic();
    logic eb, ed, ew, er;
    START0 = 1'b1; @(negedge CLK); START0 = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      eb = (c <= 10); ed = (c == 10); ew = (c <= 4); er = (c >= 5 && c <= 8);
      n_cmp++; if (BUSY0 !== eb) begin n_bad++; $display("FAIL basic_busy c=%0d: got %b want %b", c, BUSY0, eb); end
      n_cmp++; if (DONE0 !== ed) begin n_bad++; $display("FAIL basic_done c=%0d: got %b want %b", c, DONE0, ed); end
      n_cmp++; if (if0.MEM_WE !== ew || if0.MEM_RE !== er) begin n_bad++; $display("FAIL basic_we_re c=%0d: got %b%b want %b%b", c, if0.MEM_WE, if0.MEM_RE, ew, er); end
      n_cmp++; if (if0.MEM_BE !== (ew ? 4'hF : 4'h0)) begin n_bad++; $display("FAIL basic_be c=%0d: got %h want %h", c, if0.MEM_BE, (ew ? 4'hF : 4'h0)); end
      if (ew) begin
        n_cmp++; if (if0.MEM_ADDR !== 24'h100 + 24'(4*(c-1))) begin n_bad++; $display("FAIL basic_waddr c=%0d: got %0h want %0h", c, if0.MEM_ADDR, 24'h100 + 24'(4*(c-1))); end
        n_cmp++; if (if0.MEM_D !== 32'h1000 + 32'(c-1)) begin n_bad++; $display("FAIL basic_wdata c=%0d: got %0h want %0h", c, if0.MEM_D, 32'h1000 + 32'(c-1)); end
      end
      if (er) begin
        n_cmp++; if (if0.MEM_ADDR !== 24'h100 + 24'(4*(c-5))) begin n_bad++; $display("FAIL basic_raddr c=%0d: got %0h want %0h", c, if0.MEM_ADDR, 24'h100 + 24'(4*(c-5))); end
      end
      if (c < 11) @(negedge CLK);
    end
    n_cmp++; if (ERROR0 !== 1'b0 || ERRC0 !== 16'h0) begin n_bad++; $display("FAIL basic_err: got %b/%0h want 0/0", ERROR0, ERRC0); end
    n_cmp++; if (LED0 !== 8'h03) begin n_bad++; $display("FAIL basic_led: got %0h want 03", LED0); end
  endtask

  task automatic test_corrupt();
    int c;
    corrupt_en0 = 1'b1; corrupt_addr0 = 24'h000108;
    START0 = 1'b1; @(negedge CLK); START0 = 1'b0;
    repeat (8) @(negedge CLK);  // cycle 9
    n_cmp++; if (LED0 !== 8'hFD) begin n_bad++; $display("FAIL corrupt_led: got %0h want fd", LED0); end
    @(negedge CLK);             // cycle 10
    n_cmp++; if (DONE0 !== 1'b1) begin n_bad++; $display("FAIL corrupt_done: got %b want 1", DONE0); end
    n_cmp++; if (ERROR0 !== CHK) begin n_bad++; $display("FAIL corrupt_error: got %b want %b", ERROR0, CHK); end
    n_cmp++; if (ERRC0 !== {15'b0, CHK}) begin n_bad++; $display("FAIL corrupt_count: got %0h want %0h", ERRC0, {15'b0, CHK}); end
    n_cmp++; if (LED0 !== 8'h03) begin n_bad++; $display("FAIL corrupt_led_last: got %0h want 03", LED0); end
    @(negedge CLK);
    n_cmp++; if (ERROR0 !== CHK) begin n_bad++; $display("FAIL corrupt_sticky: got %b want %b", ERROR0, CHK); end
    corrupt_en0 = 1'b0;
    START0 = 1'b1; @(negedge CLK); START0 = 1'b0;
    n_cmp++; if (ERROR0 !== 1'b0 || ERRC0 !== 16'h0) begin n_bad++; $display("FAIL corrupt_clear: got %b/%0h want 0/0", ERROR0, ERRC0); end
    c = 1;
    while (DONE0 !== 1'b1 && c < 40) begin @(negedge CLK); c++; end
    n_cmp++; if (c !== 10 || ERRC0 !== 16'h0) begin n_bad++; $display("FAIL corrupt_rerun: got c=%0d cnt=%0h want c=10 cnt=0", c, ERRC0); end
    @(negedge CLK);
  endtask

  task automatic test_wrap();
    logic [23:0] ea [4];
    int c;
    ea[0] = 24'hFFFFF8; ea[1] = 24'hFFFFFC; ea[2] = 24'h000000; ea[3] = 24'h000004;
    START1 = 1'b1; @(negedge CLK); START1 = 1'b0;
    for (c = 1; c <= 8; c++) begin
      n_cmp++; if (if1.MEM_ADDR !== ea[(c-1)%4]) begin n_bad++; $display("FAIL wrap_addr c=%0d: got %0h want %0h", c, if1.MEM_ADDR, ea[(c-1)%4]); end
      @(negedge CLK);
    end
    c = 9;
    while (DONE1 !== 1'b1 && c < 40) begin @(negedge CLK); c++; end
    n_cmp++; if (c !== 10) begin n_bad++; $display("FAIL wrap_done_cycle: got %0d want 10", c); end
    @(negedge CLK);
    n_cmp++; if (ERROR1 !== 1'b0 || ERRC1 !== 16'h0 || LED1 !== 8'h03) begin n_bad++; $display("FAIL wrap_result: got %b/%0h/%0h want 0/0/03", ERROR1, ERRC1, LED1); end
  endtask

  task automatic test_latency3();
    logic eb, ed, ew, er;
    START2 = 1'b1; @(negedge CLK); START2 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      eb = (c <= 8); ed = (c == 8); ew = (c <= 2); er = (c == 3 || c == 4);
      n_cmp++; if (BUSY2 !== eb || DONE2 !== ed) begin n_bad++; $display("FAIL lat3_busy_done c=%0d: got %b%b want %b%b", c, BUSY2, DONE2, eb, ed); end
      n_cmp++; if (if2.MEM_WE !== ew || if2.MEM_RE !== er) begin n_bad++; $display("FAIL lat3_we_re c=%0d: got %b%b want %b%b", c, if2.MEM_WE, if2.MEM_RE, ew, er); end
      if (c < 9) @(negedge CLK);
    end
    n_cmp++; if (ERROR2 !== 1'b0 || ERRC2 !== 16'h0) begin n_bad++; $display("FAIL lat3_err: got %b/%0h want 0/0", ERROR2, ERRC2); end
    n_cmp++; if (LED2 !== 8'h01) begin n_bad++; $display("FAIL lat3_led: got %0h want 01", LED2); end
  endtask

  task automatic test_reset_mid();
    int c, dones;
    START0 = 1'b1; @(negedge CLK); START0 = 1'b0;
    repeat (5) @(negedge CLK);  // cycle 6, READ
    n_cmp++; if (if0.MEM_RE !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_read: got %b want 1", if0.MEM_RE); end
    RST = 1'b1; @(negedge CLK); RST = 1'b0;
    n_cmp++; if (BUSY0 !== 1'b0 || if0.MEM_RE !== 1'b0 || DONE0 !== 1'b0) begin n_bad++; $display("FAIL rstmid_abort: got %b%b%b want 000", BUSY0, if0.MEM_RE, DONE0); end
    dones = 0;
    repeat (12) begin @(negedge CLK); if (DONE0 === 1'b1 || BUSY0 === 1'b1) dones++; end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL rstmid_quiet: got %0d want 0", dones); end
    START0 = 1'b1; @(negedge CLK); START0 = 1'b0;
    c = 1;
    while (DONE0 !== 1'b1 && c < 40) begin @(negedge CLK); c++; end
    n_cmp++; if (c !== 10 || ERRC0 !== 16'h0 || ERROR0 !== 1'b0) begin n_bad++; $display("FAIL rstmid_rerun: got c=%0d cnt=%0h want c=10 cnt=0", c, ERRC0); end
    @(negedge CLK);
    n_cmp++; if (LED0 !== 8'h03) begin n_bad++; $display("FAIL rstmid_led: got %0h want 03", LED0); end
  endtask

  task automatic test_start_held();
    logic eb, ed, ew, er;
    START0 = 1'b1; @(negedge CLK);
    for (int c = 1; c <= 22; c++) begin
      if (c == 12) START0 = 1'b0;
      eb = (c <= 10) || (c >= 12 && c <= 21);
      ed = (c == 10) || (c == 21);
      ew = (c <= 4) || (c >= 12 && c <= 15);
      er = (c >= 5 && c <= 8) || (c >= 16 && c <= 19);
      n_cmp++; if (BUSY0 !== eb || DONE0 !== ed) begin n_bad++; $display("FAIL held_busy_done c=%0d: got %b%b want %b%b", c, BUSY0, DONE0, eb, ed); end
      n_cmp++; if (if0.MEM_WE !== ew || if0.MEM_RE !== er) begin n_bad++; $display("FAIL held_we_re c=%0d: got %b%b want %b%b", c, if0.MEM_WE, if0.MEM_RE, ew, er); end
      if (c == 12) begin
        n_cmp++; if (if0.MEM_ADDR !== 24'h100) begin n_bad++; $display("FAIL held_restart_addr: got %0h want 100", if0.MEM_ADDR); end
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    START0 = 1'b0; START1 = 1'b0; START2 = 1'b0;
    corrupt_en0 = 1'b0; corrupt_addr0 = 24'h0;
    RST = 1'b1;
    @(negedge CLK);
    test_reset();
    test_basic();
    test_corrupt();
    test_wrap();
    test_latency3();
    test_reset_mid();
    test_start_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
